// File: rtl/ext_mem_model.sv
// ---------------------------------------------------------------------------
// ext_mem_model
//   Backing-store memory behind the CPU+cache top level. It serves one
//   cache-line request at a time out of an internal beat-addressed array.
//   A read returns DATA_CYCLES beats after READ_LATENCY idle cycles. A write
//   consumes DATA_CYCLES byte-masked beats and returns no response.
//
// Handshake rules: a transfer happens on a rising clk edge where valid and
//   ready are both 1. Ready never depends on valid. mem_resp has no
//   backpressure. While mem_resp_valid=0, mem_resp_data holds its last value.
//
// Ports
//   clk, reset          rising-edge clock; synchronous active-low reset
//   mem_req_*           request channel: rw (1=write), line base address, tag
//   mem_req_data_*      write-beat channel: data plus byte mask (bit i -> byte i)
//   mem_resp_*          read-beat channel: valid, echoed tag, data
//
// Addressing: beat index = {addr[ADDR_BITS-1:log2(DATA_CYCLES)], beat}.
//   The low DEPTH_LOG2 bits select the array entry, and higher address bits
//   alias. DATA_CYCLES must be a power of two and at least 2.
// ---------------------------------------------------------------------------
module ext_mem_model #(
   parameter int ADDR_BITS    = 28,
   parameter int DATA_BITS    = 128,
   parameter int TAG_BITS     = 5,
   parameter int DATA_CYCLES  = 4,
   parameter int DEPTH_LOG2   = 12,
   parameter int READ_LATENCY = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   mem_req_valid,
   output logic                   mem_req_ready,
   input  logic                   mem_req_rw,
   input  logic [ADDR_BITS-1:0]   mem_req_addr,
   input  logic [TAG_BITS-1:0]    mem_req_tag,
   input  logic                   mem_req_data_valid,
   output logic                   mem_req_data_ready,
   input  logic [DATA_BITS-1:0]   mem_req_data_bits,
   input  logic [DATA_BITS/8-1:0] mem_req_data_mask,
   output logic                   mem_resp_valid,
   output logic [TAG_BITS-1:0]    mem_resp_tag,
   output logic [DATA_BITS-1:0]   mem_resp_data
);

   localparam int BEAT_BITS = $clog2(DATA_CYCLES);
   localparam int LINE_BITS = DEPTH_LOG2 - BEAT_BITS;
   localparam int DEPTH     = 1 << DEPTH_LOG2;
   localparam int MASK_BITS = DATA_BITS / 8;
   localparam int LAT_BITS  = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

   localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(DATA_CYCLES - 1);
   localparam logic [LAT_BITS-1:0]  LAST_LAT  =
      LAT_BITS'((READ_LATENCY > 0) ? READ_LATENCY - 1 : 0);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WDATA = 2'd1,
      RLAT  = 2'd2,
      RRESP = 2'd3
   } state_t;

   state_t state;
   state_t state_next;

   logic [LINE_BITS-1:0] line_q;
   logic [TAG_BITS-1:0]  tag_q;
   logic [BEAT_BITS-1:0] beat_q;
   logic [LAT_BITS-1:0]  lat_q;

   logic [DATA_BITS-1:0] mem [DEPTH];

   logic                  req_fire;
   logic                  data_fire;
   logic                  beat_last;
   logic                  enter_resp;
   logic [LINE_BITS-1:0]  req_line;
   logic [LINE_BITS-1:0]  rd_line;
   logic [BEAT_BITS-1:0]  rd_beat;
   logic [DEPTH_LOG2-1:0] rd_idx;
   logic [DEPTH_LOG2-1:0] wr_idx;
   logic [DATA_BITS-1:0]  wr_word;

   // The beat-offset bits and the aliased upper bits of the address are
   // ignored on purpose.
   logic addr_unused;
   assign addr_unused = ^{mem_req_addr[BEAT_BITS-1:0],
                          mem_req_addr[ADDR_BITS-1:DEPTH_LOG2]};

   assign req_line = mem_req_addr[BEAT_BITS +: LINE_BITS];

   // Handshakes use the registered ready outputs. After a reset the readies
   // stay low for one cycle even though the FSM is already in IDLE.
   assign req_fire  = mem_req_valid && mem_req_ready;
   assign data_fire = mem_req_data_valid && mem_req_data_ready;
   assign beat_last = (beat_q == LAST_BEAT);

   assign mem_resp_tag = tag_q;

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_next = state;
      enter_resp = 1'b0;
      unique case (state)
         IDLE: begin
            if (req_fire) begin
               if (mem_req_rw) begin
                  state_next = WDATA;
               end else if (READ_LATENCY > 0) begin
                  state_next = RLAT;
               end else begin
                  state_next = RRESP;
                  enter_resp = 1'b1;
               end
            end
         end
         WDATA: begin
            if (data_fire && beat_last) state_next = IDLE;
         end
         RLAT: begin
            if (lat_q == LAST_LAT) begin
               state_next = RRESP;
               enter_resp = 1'b1;
            end
         end
         RRESP: begin
            if (beat_last) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Array addressing. The response data register is loaded on the edge
   // before each beat is shown, so the read index always points one beat
   // ahead of the beat that is currently on the bus. With zero latency the
   // first beat is fetched in the same cycle as the accept, before line_q
   // holds the new line, so the line then comes straight from the request.
   // ------------------------------------------------------------------
   always_comb begin
      rd_line = (state == IDLE) ? req_line : line_q;
      rd_beat = enter_resp ? '0 : beat_q + 1'b1;
      rd_idx  = {rd_line, rd_beat};
      wr_idx  = {line_q, beat_q};
   end

   // Read-modify-write merge: unmasked bytes keep their stored value.
   always_comb begin
      wr_word = mem[wr_idx];
      for (int i = 0; i < MASK_BITS; i++) begin
         if (mem_req_data_mask[i]) wr_word[8*i +: 8] = mem_req_data_bits[8*i +: 8];
      end
   end

   // The array is never cleared. A write is blocked on a reset cycle so that
   // an aborted burst leaves nothing behind.
   always_ff @(posedge clk) begin
      if (reset && data_fire) mem[wr_idx] <= wr_word;
   end

   // ------------------------------------------------------------------
   // State register, control counters, and registered outputs
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset) begin
         state              <= IDLE;
         line_q             <= '0;
         tag_q              <= '0;
         beat_q             <= '0;
         lat_q              <= '0;
         mem_req_ready      <= 1'b0;
         mem_req_data_ready <= 1'b0;
         mem_resp_valid     <= 1'b0;
         mem_resp_data      <= '0;
      end else begin
         state              <= state_next;
         mem_req_ready      <= (state_next == IDLE);
         mem_req_data_ready <= (state_next == WDATA);
         mem_resp_valid     <= (state_next == RRESP);

         if (req_fire) begin
            line_q <= req_line;
            tag_q  <= mem_req_tag;
            beat_q <= '0;
            lat_q  <= '0;
         end

         // After the last write beat the counter wraps back to zero.
         if (state == WDATA && data_fire) beat_q <= beat_q + 1'b1;

         if (state == RLAT) lat_q <= lat_q + 1'b1;

         if (enter_resp) begin
            beat_q        <= '0;
            mem_resp_data <= mem[rd_idx];
         end else if (state == RRESP && !beat_last) begin
            beat_q        <= beat_q + 1'b1;
            mem_resp_data <= mem[rd_idx];
         end
      end
   end

endmodule

// File: tb/tb_ext_mem_model.sv
// ---------------------------------------------------------------------------
// tb_ext_mem_model
//   Directed bench for ext_mem_model with its default parameters. It covers
//   the reset state, a full-line write and readback, a partial byte write,
//   write-data bubbles, address alignment and aliasing, back-to-back reads,
//   and a reset that aborts a read burst and a write burst part-way through.
//   Expected read beats are pushed into exp_q and popped as beats arrive.
// ---------------------------------------------------------------------------
module tb_ext_mem_model;

   localparam int AW = 28;
   localparam int DW = 128;
   localparam int TW = 5;
   localparam int MW = DW / 8;
   localparam int NB = 4;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   logic          mem_req_valid = 1'b0;
   logic          mem_req_ready;
   logic          mem_req_rw = 1'b0;
   logic [AW-1:0] mem_req_addr = '0;
   logic [TW-1:0] mem_req_tag = '0;
   logic          mem_req_data_valid = 1'b0;
   logic          mem_req_data_ready;
   logic [DW-1:0] mem_req_data_bits = '0;
   logic [MW-1:0] mem_req_data_mask = '0;
   logic          mem_resp_valid;
   logic [TW-1:0] mem_resp_tag;
   logic [DW-1:0] mem_resp_data;

   ext_mem_model dut (
      .clk                (clk),
      .reset              (reset),
      .mem_req_valid      (mem_req_valid),
      .mem_req_ready      (mem_req_ready),
      .mem_req_rw         (mem_req_rw),
      .mem_req_addr       (mem_req_addr),
      .mem_req_tag        (mem_req_tag),
      .mem_req_data_valid (mem_req_data_valid),
      .mem_req_data_ready (mem_req_data_ready),
      .mem_req_data_bits  (mem_req_data_bits),
      .mem_req_data_mask  (mem_req_data_mask),
      .mem_resp_valid     (mem_resp_valid),
      .mem_resp_tag       (mem_resp_tag),
      .mem_resp_data      (mem_resp_data)
   );

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_pass   = 0;
   logic [DW-1:0] exp_q[$];

   logic [DW-1:0] wbeat [NB];
   logic [MW-1:0] wmask [NB];

   localparam logic [DW-1:0] BASE_A = 128'h1111_2222_3333_4444_5555_6666_7777_00A0;
   localparam logic [DW-1:0] BASE_B = 128'h8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE_00B0;
   localparam logic [DW-1:0] BASE_C = 128'h0123_4567_89AB_CDEF_0F1E_2D3C_4B5A_00C0;
   localparam logic [DW-1:0] BASE_D = 128'hDEAD_BEEF_CAFE_F00D_1234_5678_9ABC_00D0;

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // ---------------- driver tasks ----------------
   // Inputs are driven and outputs sampled 1 time unit after each rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_req_ready(input string tag);
      int n = 0;
      while (!mem_req_ready && n < 20) begin
         tick();
         n++;
      end
      check(tag, DW'(mem_req_ready), DW'(1));
   endtask

   task automatic fill_line(input logic [DW-1:0] base);
      for (int b = 0; b < NB; b++) begin
         wbeat[b] = base + DW'(b);
         wmask[b] = '1;
      end
   endtask

   task automatic push_line(input logic [DW-1:0] base);
      for (int b = 0; b < NB; b++) exp_q.push_back(base + DW'(b));
   endtask

   // Writes wbeat/wmask to one line. With bubbles set, each beat follows a
   // cycle in which data_valid is low.
   task automatic write_line(input logic [AW-1:0] addr, input logic [TW-1:0] tag, input logic bubbles);
      mem_req_valid = 1'b1;
      mem_req_rw    = 1'b1;
      mem_req_addr  = addr;
      mem_req_tag   = tag;
      wait_req_ready("wr_req_ready");
      tick();
      mem_req_valid = 1'b0;
      for (int b = 0; b < NB; b++) begin
         if (bubbles) begin
            mem_req_data_valid = 1'b0;
            tick();
            check("wr_bubble_req_ready", DW'(mem_req_ready), DW'(0));
         end
         mem_req_data_valid = 1'b1;
         mem_req_data_bits  = wbeat[b];
         mem_req_data_mask  = wmask[b];
         check("wr_data_ready", DW'(mem_req_data_ready), DW'(1));
         check("wr_req_ready_low", DW'(mem_req_ready), DW'(0));
         tick();
      end
      mem_req_data_valid = 1'b0;
      check("wr_done_req_ready", DW'(mem_req_ready), DW'(1));
      check("wr_done_data_ready", DW'(mem_req_data_ready), DW'(0));
   endtask

   // Reads one line and checks latency, tag and 4 beats against exp_q. With
   // keep set, req_valid stays high for a following back-to-back request.
   task automatic read_line(input logic [AW-1:0] addr, input logic [TW-1:0] tag, input logic keep);
      int n;
      mem_req_valid = 1'b1;
      mem_req_rw    = 1'b0;
      mem_req_addr  = addr;
      mem_req_tag   = tag;
      wait_req_ready("rd_req_ready");
      tick();
      if (!keep) mem_req_valid = 1'b0;
      check("rd_gap_req_ready", DW'(mem_req_ready), DW'(0));
      n = 1;
      while (!mem_resp_valid && n < 20) begin
         tick();
         n++;
      end
      check("rd_latency", DW'(n), DW'(3));
      for (int b = 0; b < NB; b++) begin
         check("rd_valid", DW'(mem_resp_valid), DW'(1));
         check("rd_tag", DW'(mem_resp_tag), DW'(tag));
         if (exp_q.size() > 0) check("rd_data", mem_resp_data, exp_q.pop_front());
         else check("rd_exp_empty", DW'(0), DW'(1));
         tick();
      end
      check("rd_end_valid", DW'(mem_resp_valid), DW'(0));
      check("rd_end_req_ready", DW'(mem_req_ready), DW'(1));
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [DW-1:0] a1_patched;

      // Reset state
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("rst_req_ready", DW'(mem_req_ready), DW'(0));
         check("rst_resp_valid", DW'(mem_resp_valid), DW'(0));
         check("rst_data_ready", DW'(mem_req_data_ready), DW'(0));
      end
      reset = 1'b1;
      tick();
      check("post_rst_req_ready", DW'(mem_req_ready), DW'(1));

      // Full-line write to 0x40, then readback with another tag
      fill_line(BASE_A);
      write_line(28'h40, 5'd3, 1'b0);
      push_line(BASE_A);
      read_line(28'h40, 5'd7, 1'b0);

      // Partial write: only byte 0 of beat 1 is enabled
      for (int b = 0; b < NB; b++) begin
         wbeat[b] = '1;
         wmask[b] = '0;
      end
      wbeat[1] = 128'hFF;
      wmask[1] = 16'h0001;
      write_line(28'h40, 5'd4, 1'b0);
      a1_patched = (BASE_A + DW'(1)) & ~(128'hFF);
      a1_patched = a1_patched | 128'hFF;
      exp_q.push_back(BASE_A);
      exp_q.push_back(a1_patched);
      exp_q.push_back(BASE_A + DW'(2));
      exp_q.push_back(BASE_A + DW'(3));
      read_line(28'h40, 5'd8, 1'b0);

      // Write with data bubbles to 0x80
      fill_line(BASE_B);
      write_line(28'h80, 5'd5, 1'b1);
      push_line(BASE_B);
      read_line(28'h80, 5'd9, 1'b0);

      // Low bits ignored (0x43 -> line 0x40), upper bits alias (0x1040 -> 0x40)
      fill_line(BASE_C);
      write_line(28'h43, 5'd6, 1'b0);
      push_line(BASE_C);
      read_line(28'h1040, 5'd10, 1'b0);

      // Back-to-back reads with req_valid held high
      push_line(BASE_C);
      read_line(28'h40, 5'd1, 1'b1);
      push_line(BASE_B);
      read_line(28'h80, 5'd2, 1'b1);
      push_line(BASE_C);
      read_line(28'h1040, 5'd3, 1'b0);

      // Reset in the middle of a read burst
      mem_req_valid = 1'b1;
      mem_req_rw    = 1'b0;
      mem_req_addr  = 28'h80;
      mem_req_tag   = 5'd11;
      wait_req_ready("abort_rd_req_ready");
      tick();
      mem_req_valid = 1'b0;
      tick();
      tick();
      check("abort_rd_beat0", mem_resp_data, BASE_B);
      tick();
      check("abort_rd_beat1", mem_resp_data, BASE_B + DW'(1));
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("abort_rd_resp_valid", DW'(mem_resp_valid), DW'(0));
         check("abort_rd_req_ready", DW'(mem_req_ready), DW'(0));
      end
      reset = 1'b1;
      tick();
      check("abort_rd_release_ready", DW'(mem_req_ready), DW'(1));
      check("abort_rd_release_valid", DW'(mem_resp_valid), DW'(0));
      tick();
      check("abort_rd_quiet", DW'(mem_resp_valid), DW'(0));

      // Reset in the middle of a write burst: only beats 0 and 1 land
      mem_req_valid = 1'b1;
      mem_req_rw    = 1'b1;
      mem_req_addr  = 28'h80;
      mem_req_tag   = 5'd12;
      wait_req_ready("abort_wr_req_ready");
      tick();
      mem_req_valid = 1'b0;
      mem_req_data_mask = '1;
      for (int b = 0; b < 2; b++) begin
         mem_req_data_valid = 1'b1;
         mem_req_data_bits  = BASE_D + DW'(b);
         tick();
      end
      mem_req_data_bits = BASE_D + DW'(2);
      reset = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      check("abort_wr_data_ready", DW'(mem_req_data_ready), DW'(0));
      tick();
      check("abort_wr_data_ready_idle", DW'(mem_req_data_ready), DW'(0));
      check("abort_wr_req_ready", DW'(mem_req_ready), DW'(1));
      mem_req_data_valid = 1'b0;
      exp_q.push_back(BASE_D);
      exp_q.push_back(BASE_D + DW'(1));
      exp_q.push_back(BASE_B + DW'(2));
      exp_q.push_back(BASE_B + DW'(3));
      read_line(28'h80, 5'd13, 1'b0);

      // ---------------- final report ----------------
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
